// File: rtl/cpu6502_pkg.sv
// ============================================================================
// Module      : cpu6502_pkg
// Description : Shared 6502 constants: stack-sequencer state encoding, stack
//               page default, bus direction values and byte-select helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu6502_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH_WR  = 3'd1;
    localparam logic [2:0] ST_PULL_INC = 3'd2;
    localparam logic [2:0] ST_PULL_RD  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        STATE_IDLE     = ST_IDLE,
        STATE_PUSH_WR  = ST_PUSH_WR,
        STATE_PULL_INC = ST_PULL_INC,
        STATE_PULL_RD  = ST_PULL_RD,
        STATE_DONE     = ST_DONE
    } seq_state_t;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
    localparam logic       RW_READ            = 1'b1;
    localparam logic       RW_WRITE           = 1'b0;

    // Bytes go out most-significant first, counting only the low LEN bytes.
    function automatic logic [7:0] push_byte(
        input logic [23:0] data,
        input logic [1:0]  len,
        input logic [1:0]  cnt
    );
        logic [1:0] idx;
        idx = len - cnt - 2'd1;
        case (idx)
            2'd0:    push_byte = data[7:0];
            2'd1:    push_byte = data[15:8];
            default: push_byte = data[23:16];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_sequencer.sv
// ============================================================================
// Module      : stack_sequencer
// Description : Sequences 1-3 byte 6502 stack pushes/pulls, driving stack-page
//               bus cycles, S register load strobes and assembled pull data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_sequencer
    import cpu6502_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_push,
    input  logic        i_pull,
    input  logic [1:0]  i_len,
    input  logic [23:0] i_push_data,
    input  logic [7:0]  i_s,
    input  logic [7:0]  i_bus_data,
    output logic [7:0]  o_s_data,
    output logic        o_s_load,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_rw,
    output logic [23:0] o_pull_data,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_wrap
);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    logic [7:0]  r_sp;
    logic [1:0]  r_cnt;
    logic [1:0]  r_len;
    logic [23:0] r_data;
    logic [23:0] r_pull_data;

    logic [1:0]  w_len;
    logic        w_last;
    logic        w_s_load;
    logic [7:0]  w_s_data;
    logic        w_rw;
    logic [7:0]  w_data;
    logic        w_wrap;

    assign w_len  = (i_len == 2'd0) ? 2'd1 : i_len;
    assign w_last = (r_cnt == (r_len - 2'd1));

    always_comb begin
        w_next_state = r_state;
        w_s_load     = 1'b0;
        w_s_data     = r_sp;
        w_rw         = RW_READ;
        w_data       = 8'h00;
        w_wrap       = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                if (i_push) begin
                    w_next_state = STATE_PUSH_WR;
                end else if (i_pull) begin
                    w_next_state = STATE_PULL_INC;
                end
            end
            STATE_PUSH_WR: begin
                w_rw     = RW_WRITE;
                w_data   = push_byte(r_data, r_len, r_cnt);
                w_s_load = 1'b1;
                w_s_data = r_sp - 8'd1;
                w_wrap   = (r_sp == 8'h00);
                if (w_last) begin
                    w_next_state = STATE_DONE;
                end
            end
            STATE_PULL_INC: begin
                w_s_load     = 1'b1;
                w_s_data     = r_sp + 8'd1;
                w_wrap       = (r_sp == 8'hFF);
                w_next_state = STATE_PULL_RD;
            end
            STATE_PULL_RD: begin
                if (w_last) begin
                    w_next_state = STATE_DONE;
                end else begin
                    w_s_load = 1'b1;
                    w_s_data = r_sp + 8'd1;
                    w_wrap   = (r_sp == 8'hFF);
                end
            end
            STATE_DONE: begin
                w_next_state = STATE_IDLE;
            end
            default: begin
                w_next_state = STATE_IDLE;
            end
        endcase
    end

    // r_sp mirrors every S load so the bus address never follows the negedge S update.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= STATE_IDLE;
            r_sp        <= 8'hFF;
            r_cnt       <= 2'd0;
            r_len       <= 2'd1;
            r_data      <= 24'h000000;
            r_pull_data <= 24'h000000;
        end else begin
            r_state <= w_next_state;
            if (r_state == STATE_IDLE) begin
                if (i_push || i_pull) begin
                    r_sp   <= i_s;
                    r_cnt  <= 2'd0;
                    r_len  <= w_len;
                    r_data <= i_push_data;
                end
                if (!i_push && i_pull) begin
                    r_pull_data <= 24'h000000;
                end
            end else if (w_s_load) begin
                r_sp <= w_s_data;
            end
            if (r_state == STATE_PUSH_WR) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (r_state == STATE_PULL_RD) begin
                r_cnt <= r_cnt + 2'd1;
                case (r_cnt)
                    2'd0:    r_pull_data[7:0]   <= i_bus_data;
                    2'd1:    r_pull_data[15:8]  <= i_bus_data;
                    default: r_pull_data[23:16] <= i_bus_data;
                endcase
            end
        end
    end

    assign o_s_data    = w_s_data;
    assign o_s_load    = w_s_load;
    assign o_address   = {STACK_PAGE, r_sp};
    assign o_data      = w_data;
    assign o_rw        = w_rw;
    assign o_pull_data = r_pull_data;
    assign o_done      = (r_state == STATE_DONE);
    assign o_busy      = (r_state != STATE_IDLE);
    assign o_wrap      = w_wrap;

endmodule

`default_nettype wire

// File: tb/tb_stack_sequencer.sv
// ============================================================================
// Module      : tb_stack_sequencer
// Description : Directed self-checking bench for stack_sequencer with an S
//               register model and a stack-page memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_push;
    logic        i_pull;
    logic [1:0]  i_len;
    logic [23:0] i_push_data;
    logic [7:0]  i_s;
    logic [7:0]  i_bus_data;
    logic [7:0]  o_s_data;
    logic        o_s_load;
    logic [15:0] o_address;
    logic [7:0]  o_data;
    logic        o_rw;
    logic [23:0] o_pull_data;
    logic        o_done;
    logic        o_busy;
    logic        o_wrap;

    logic [7:0]  mem [256];
    logic [7:0]  s_reg;
    logic        s_set;
    logic [7:0]  s_set_val;
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [7:0]  poke_val;

    int n_pass  = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    stack_sequencer #(.STACK_PAGE(8'h01)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (i_push),
        .i_pull      (i_pull),
        .i_len       (i_len),
        .i_push_data (i_push_data),
        .i_s         (i_s),
        .i_bus_data  (i_bus_data),
        .o_s_data    (o_s_data),
        .o_s_load    (o_s_load),
        .o_address   (o_address),
        .o_data      (o_data),
        .o_rw        (o_rw),
        .o_pull_data (o_pull_data),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_wrap      (o_wrap)
    );

    // S register: captures on negedge, like the real Register instance.
    always @(negedge i_clk) begin
        if (s_set) s_reg <= s_set_val;
        else if (o_s_load) s_reg <= o_s_data;
    end
    assign i_s = s_reg;

    always @(posedge i_clk) begin
        if (poke_en) mem[poke_addr] <= poke_val;
        else if (!o_rw && o_address[15:8] == 8'h01) mem[o_address[7:0]] <= o_data;
    end
    assign i_bus_data = mem[o_address[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_s(input logic [7:0] v);
        s_set = 1'b1;
        s_set_val = v;
        step();
        s_set = 1'b0;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        poke_en = 1'b1;
        poke_addr = a;
        poke_val = v;
        step();
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic push, input logic pull, input logic [1:0] len, input logic [23:0] data);
        i_push = push;
        i_pull = pull;
        i_len = len;
        i_push_data = data;
        step();
        i_push = 1'b0;
        i_pull = 1'b0;
    endtask

    logic [7:0] b3 [3];

    initial begin
        i_reset_n = 1'b0;
        i_push = 1'b0;
        i_pull = 1'b0;
        i_len = 2'd0;
        i_push_data = 24'h0;
        s_set = 1'b1;
        s_set_val = 8'hFF;
        poke_en = 1'b0;
        poke_addr = 8'h00;
        poke_val = 8'h00;
        b3[0] = 8'h12; b3[1] = 8'h34; b3[2] = 8'h56;

        #12;
        check("rst_addr", o_address, 16'h01FF);
        check("rst_rw", o_rw, 1);
        check("rst_sload", o_s_load, 0);
        check("rst_data", o_data, 0);
        check("rst_pull", o_pull_data, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        check("rst_wrap", o_wrap, 0);
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        s_set = 1'b0;

        // push len=1 at S=FF
        set_s(8'hFF);
        issue(1, 0, 2'd1, 24'h0000AB);
        check("p1_addr", o_address, 16'h01FF);
        check("p1_rw", o_rw, 0);
        check("p1_data", o_data, 8'hAB);
        check("p1_sload", o_s_load, 1);
        check("p1_sdata", o_s_data, 8'hFE);
        check("p1_wrap", o_wrap, 0);
        check("p1_busy", o_busy, 1);
        step();
        check("p1_done", o_done, 1);
        check("p1_done_rw", o_rw, 1);
        check("p1_done_sload", o_s_load, 0);
        step();
        check("p1_idle_done", o_done, 0);
        check("p1_idle_busy", o_busy, 0);
        check("p1_s", s_reg, 8'hFE);

        // push len=3 at S=FD
        set_s(8'hFD);
        issue(1, 0, 2'd3, 24'h123456);
        for (int k = 0; k < 3; k++) begin
            check("p3_addr", o_address, 16'h01FD - 16'(k));
            check("p3_data", o_data, b3[k]);
            check("p3_sdata", o_s_data, 8'hFC - 8'(k));
            check("p3_done_early", o_done, 0);
            step();
        end
        check("p3_done", o_done, 1);
        step();
        check("p3_s", s_reg, 8'hFA);

        // pull len=2 at S=FA
        poke(8'hFB, 8'h78);
        poke(8'hFC, 8'h9A);
        set_s(8'hFA);
        issue(0, 1, 2'd2, 24'h0);
        check("u2_dummy_addr", o_address, 16'h01FA);
        check("u2_dummy_rw", o_rw, 1);
        check("u2_dummy_sload", o_s_load, 1);
        check("u2_dummy_sdata", o_s_data, 8'hFB);
        check("u2_dummy_pull", o_pull_data, 0);
        step();
        check("u2_rd0_addr", o_address, 16'h01FB);
        check("u2_rd0_sload", o_s_load, 1);
        check("u2_rd0_sdata", o_s_data, 8'hFC);
        step();
        check("u2_rd1_addr", o_address, 16'h01FC);
        check("u2_rd1_sload", o_s_load, 0);
        check("u2_rd1_done", o_done, 0);
        step();
        check("u2_done", o_done, 1);
        check("u2_pull", o_pull_data, 24'h009A78);
        step();
        check("u2_busy", o_busy, 0);
        check("u2_pull_hold", o_pull_data, 24'h009A78);
        check("u2_s", s_reg, 8'hFC);

        // wrap on push at S=00, then pull back at S=FF
        set_s(8'h00);
        issue(1, 0, 2'd1, 24'h000055);
        check("wp_addr", o_address, 16'h0100);
        check("wp_sdata", o_s_data, 8'hFF);
        check("wp_wrap", o_wrap, 1);
        step();
        step();
        check("wp_s", s_reg, 8'hFF);
        issue(0, 1, 2'd1, 24'h0);
        check("wu_addr", o_address, 16'h01FF);
        check("wu_sdata", o_s_data, 8'h00);
        check("wu_wrap", o_wrap, 1);
        step();
        check("wu_rd_addr", o_address, 16'h0100);
        check("wu_rd_wrap", o_wrap, 0);
        step();
        check("wu_done", o_done, 1);
        check("wu_pull", o_pull_data, 24'h000055);
        step();

        // push and pull together: push wins
        set_s(8'h80);
        issue(1, 1, 2'd2, 24'h00BEEF);
        check("pp_rw", o_rw, 0);
        check("pp_addr0", o_address, 16'h0180);
        check("pp_data0", o_data, 8'hBE);
        step();
        check("pp_addr1", o_address, 16'h017F);
        check("pp_data1", o_data, 8'hEF);
        step();
        check("pp_done", o_done, 1);
        step();
        check("pp_s", s_reg, 8'h7E);
        check("pp_pull_kept", o_pull_data, 24'h000055);

        // pull pulsed while busy is ignored
        set_s(8'h40);
        issue(1, 0, 2'd2, 24'h00C3D4);
        i_pull = 1'b1;
        step();
        i_pull = 1'b0;
        check("bz_data1", o_data, 8'hD4);
        check("bz_rw", o_rw, 0);
        step();
        check("bz_done", o_done, 1);
        step();
        check("bz_idle", o_busy, 0);
        step();
        check("bz_still_idle", o_busy, 0);
        check("bz_s", s_reg, 8'h3E);

        // len=0 behaves as len=1
        set_s(8'h10);
        issue(1, 0, 2'd0, 24'h000077);
        check("l0_data", o_data, 8'h77);
        check("l0_sdata", o_s_data, 8'h0F);
        step();
        check("l0_done", o_done, 1);
        step();
        check("l0_s", s_reg, 8'h0F);

        // reset during 2nd byte of a 3-byte push
        set_s(8'hF0);
        issue(1, 0, 2'd3, 24'h112233);
        check("rm_data0", o_data, 8'h11);
        step();
        check("rm_data1", o_data, 8'h22);
        check("rm_addr1", o_address, 16'h01EF);
        i_reset_n = 1'b0;
        #1;
        check("rm_busy", o_busy, 0);
        check("rm_rw", o_rw, 1);
        check("rm_done", o_done, 0);
        check("rm_sload", o_s_load, 0);
        check("rm_pull", o_pull_data, 0);
        check("rm_addr", o_address, 16'h01FF);
        #2;
        i_reset_n = 1'b1;
        step();
        check("rm_after_done", o_done, 0);
        check("rm_after_busy", o_busy, 0);
        check("rm_s", s_reg, 8'hEF);
        issue(0, 1, 2'd1, 24'h0);
        check("rs_addr", o_address, 16'h01EF);
        check("rs_sdata", o_s_data, 8'hF0);
        step();
        check("rs_rd_addr", o_address, 16'h01F0);
        step();
        check("rs_done", o_done, 1);
        check("rs_pull", o_pull_data, 24'h000011);
        step();
        check("rs_s", s_reg, 8'hF0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
